// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: FSM states,
// pattern count, table width and a table-slice helper.
package truth_table_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int N_PATTERNS = 8;
    localparam int TABLE_W    = 16;

    function automatic logic [1:0] table_slice(
        input logic [TABLE_W-1:0] tbl,
        input logic [2:0]         idx
    );
        return tbl[2*idx +: 2];
    endfunction

endpackage

// File: rtl/truth_table_scanner_hold_counter.sv
// Per-pattern hold counter; 'last' marks the capture cycle of a pattern.
// Wraps to zero on the capture edge so the next pattern starts fresh.
module scan_hold_counter #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last
);

    localparam logic [7:0] LAST_VAL = 8'(HOLD_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign last = (cnt_q == LAST_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = last ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks {A,B,C} through all 8 patterns and captures {X,Y} per pattern.
// Optional check against EXPECTED is built when SCAN_COMPARE_EN is defined.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int          HOLD_CYCLES = 10,
    parameter logic [15:0] EXPECTED    = 16'hD668
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        X,
    input  logic        Y,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [3:0]  mismatch_cnt,
    output logic        pass
);

    localparam logic [2:0] LAST_IDX = 3'(N_PATTERNS - 1);

    state_e               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [2:0]           abc_q, abc_d;
    logic [TABLE_W-1:0]   table_q, table_d;
    logic                 accept;
    logic                 cnt_en;
    logic                 last;

    scan_hold_counter #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk  (clk),
        .rst  (rst),
        .clear(accept),
        .en   (cnt_en),
        .last (last)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        table_d = table_q;
        accept  = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = 3'd0;
                    table_d = '0;
                    accept  = 1'b1;
                end
            end
            DRIVE: begin
                cnt_en = 1'b1;
                if (last) begin
                    table_d[2*idx_q +: 2] = {X, Y};
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Pattern outputs are registered copies of the next index.
        abc_d = (state_d == DRIVE) ? idx_d : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            abc_q   <= 3'd0;
            table_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            abc_q   <= abc_d;
            table_q <= table_d;
        end
    end

    assign {A, B, C} = abc_q;
    assign busy      = (state_q == DRIVE);
    assign done      = (state_q == DONE);
    assign table_out = table_q;

`ifdef SCAN_COMPARE_EN
    logic [3:0] mm_q, mm_d;
    logic       pass_q, pass_d;

    always_comb begin
        mm_d = mm_q;
        if (accept) begin
            mm_d = 4'd0;
        end else if (cnt_en && last &&
                     (table_slice(EXPECTED, idx_q) != {X, Y})) begin
            mm_d = mm_q + 4'd1;
        end
        pass_d = (state_d == DONE) && (mm_d == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mm_q   <= 4'd0;
            pass_q <= 1'b0;
        end else begin
            mm_q   <= mm_d;
            pass_q <= pass_d;
        end
    end

    assign mismatch_cnt = mm_q;
    assign pass         = pass_q;
`else
    logic unused_expected;
    assign unused_expected = ^EXPECTED;
    assign mismatch_cnt    = 4'd0;
    assign pass            = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized bench for truth_table_scanner (HOLD_CYCLES=10 and 1)
// against a cycle-count based scan model; full-adder task block.
module tb_truth_table_scanner;

    localparam logic [15:0] EXP = 16'hD668;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, stuck, start0, start1;

    logic a0, b0, c0, x0, y0, busy0, done0, pass0;
    logic [15:0] tbl0;
    logic [3:0]  mm0;
    logic a1, b1, c1, x1, y1, busy1, done1, pass1;
    logic [15:0] tbl1;
    logic [3:0]  mm1;

    assign x0 = stuck ? 1'b0 : (a0 ^ b0 ^ c0);
    assign y0 = (a0 & b0) | (a0 & c0) | (b0 & c0);
    assign x1 = stuck ? 1'b0 : (a1 ^ b1 ^ c1);
    assign y1 = (a1 & b1) | (a1 & c1) | (b1 & c1);

    truth_table_scanner #(.HOLD_CYCLES(10), .EXPECTED(EXP)) dut (
        .clk(clk), .rst(rst), .start(start0), .X(x0), .Y(y0),
        .A(a0), .B(b0), .C(c0), .busy(busy0), .done(done0),
        .table_out(tbl0), .mismatch_cnt(mm0), .pass(pass0)
    );

    truth_table_scanner #(.HOLD_CYCLES(1), .EXPECTED(EXP)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .X(x1), .Y(y1),
        .A(a1), .B(b1), .C(c1), .busy(busy1), .done(done1),
        .table_out(tbl1), .mismatch_cnt(mm1), .pass(pass1)
    );

    int vecs = 0;
    int errs = 0;

    // Scan model: position in the scan follows from cycles since accept.
    int          hold [2] = '{10, 1};
    int          cyc = 0;
    int          e0 [2];
    bit          act [2];
    bit          dn [2];
    logic [15:0] mt [2];
    int          mmc [2];

    function automatic logic [1:0] fa(input int i, input bit s);
        int a, b, c, sum, cy;
        a = (i >> 2) & 1;
        b = (i >> 1) & 1;
        c = i & 1;
        sum = (a + b + c) & 1;
        cy = (a + b + c) >= 2 ? 1 : 0;
        return {(s ? 1'b0 : 1'(sum)), 1'(cy)};
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int j = 0; j < 2; j++) begin
            bit st;
            st = (j == 0) ? start0 : start1;
            if (rst) begin
                act[j] = 0; dn[j] = 0; mt[j] = '0; mmc[j] = 0;
            end else if (!act[j] && st) begin
                act[j] = 1; dn[j] = 0; e0[j] = cyc; mt[j] = '0; mmc[j] = 0;
            end else if (act[j]) begin
                int k, i;
                logic [1:0] v;
                k = cyc - e0[j];
                if (k % hold[j] == 0) begin
                    i = k / hold[j] - 1;
                    v = fa(i, stuck);
                    mt[j] = mt[j] | ({14'd0, v} << (2 * i));
                    if (32'(v) != ((32'(EXP) >> (2 * i)) & 3)) mmc[j]++;
                    if (i == 7) begin
                        act[j] = 0; dn[j] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int j = 0; j < 2; j++) begin
                logic [25:0] got, want;
                logic [2:0]  eabc;
                logic [3:0]  emm;
                logic        epass;
                eabc = act[j] ? 3'((cyc - e0[j]) / hold[j]) : 3'd0;
`ifdef SCAN_COMPARE_EN
                emm = 4'(mmc[j]);
                epass = dn[j] && (mmc[j] == 0);
`else
                emm = 4'd0;
                epass = 1'b0;
`endif
                want = {eabc, act[j], dn[j], mt[j], emm, epass};
                if (j == 0) got = {a0, b0, c0, busy0, done0, tbl0, mm0, pass0};
                else        got = {a1, b1, c1, busy1, done1, tbl1, mm1, pass1};
                vecs++;
                if (got !== want) begin
                    errs++;
                    $display("FAIL model inst%0d cyc %0d: got %h want %h (abc,busy,done,table,mm,pass)",
                             j, cyc, got, want);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic wait_done0(input int lim);
        int n;
        n = 0;
        while (!done0 && n < lim) begin
            tick();
            n++;
        end
        chk("done0_timeout", 32'(done0), 32'd1);
    endtask

    initial begin
        int t0;
        rst = 1; stuck = 0; start0 = 0; start1 = 0;
        tick(); tick();
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_table", 32'(tbl0), 0);
        chk("rst_abc", 32'({a0, b0, c0}), 0);
        rst = 0;
        tick();

        // Full-adder scan, with a start at cycle 25 that must be ignored.
        start0 = 1; start1 = 1;
        tick();
        t0 = cyc;
        start0 = 0; start1 = 0;
        repeat (24) tick();
        start0 = 1; tick(); start0 = 0;
        wait_done0(200);
        chk("fa_latency", 32'(cyc - t0), 32'd80);
        chk("fa_table", 32'(tbl0), 32'hD668);
        chk("fa_table_h1", 32'(tbl1), 32'hD668);
`ifdef SCAN_COMPARE_EN
        chk("fa_mm", 32'(mm0), 0);
        chk("fa_pass", 32'(pass0), 1);
`endif

        // Restart from DONE.
        start0 = 1; tick(); start0 = 0;
        chk("restart_done", 32'(done0), 0);
        chk("restart_table", 32'(tbl0), 0);
        wait_done0(200);
        chk("restart_final", 32'(tbl0), 32'hD668);

        // X stuck at 0.
        stuck = 1;
        start0 = 1; start1 = 1; tick(); start0 = 0; start1 = 0;
        wait_done0(200);
        chk("stuck_table", 32'(tbl0), 32'h5440);
        chk("stuck_table_h1", 32'(tbl1), 32'h5440);
`ifdef SCAN_COMPARE_EN
        chk("stuck_mm", 32'(mm0), 4);
        chk("stuck_pass", 32'(pass0), 0);
`endif
        stuck = 0;

        // Reset at cycle 37, with a start in the same cycle.
        start0 = 1; tick(); start0 = 0;
        repeat (36) tick();
        rst = 1; start0 = 1; tick(); rst = 0; start0 = 0;
        chk("midrst_busy", 32'(busy0), 0);
        chk("midrst_done", 32'(done0), 0);
        chk("midrst_table", 32'(tbl0), 0);
        chk("midrst_abc", 32'({a0, b0, c0}), 0);
        tick();
        start0 = 1; tick(); start0 = 0;
        wait_done0(200);
        chk("after_rst_table", 32'(tbl0), 32'hD668);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            start0 = ($urandom % 16) == 0;
            start1 = ($urandom % 6) == 0;
            rst = ($urandom % 400) == 0;
            if ((n % 50) == 0) stuck = $urandom % 2;
            tick();
        end
        rst = 0; start0 = 0; start1 = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
